// File: rtl/seg7_step_counter_pkg.sv
// Shared types, glyph table and counter range for the seven-segment step counter.
// Defining SEG7_DECIMAL_EN restricts the counter to 0..9.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

`ifdef SEG7_DECIMAL_EN
  localparam logic [3:0] VALUE_MAX = 4'd9;
`else
  localparam logic [3:0] VALUE_MAX = 4'd15;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_step_counter_if.sv
// Switch/divider inputs and display outputs of the step counter, grouped as one bundle.
interface seg7_step_counter_if;
  logic       clk_div;
  logic       run;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] value;

  modport master (output clk_div, run, dir, load, load_val,
                  input  seg, dp, value);
  modport slave  (input  clk_div, run, dir, load, load_val,
                  output seg, dp, value);
endinterface

// File: rtl/seg7_step_counter_encode.sv
// Registered hex-to-seven-segment encoder; seg trails its input value by one clock.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg <= GLYPH_0;
    else       seg <= hex_to_seg(value);
  end

endmodule

// File: rtl/seg7_step_counter.sv
// Up/down step counter driven by divider ticks, with wrap indicator on dp.
// Optional macro SEG7_DECIMAL_EN limits the range to 0..9 and saturates loads at 9.
module seg7_step_counter
  import seg7_pkg::*;
#(
  parameter int STEP_DIV = 4,
  parameter int DP_HOLD  = 1
) (
  input logic               clk,
  input logic               reset,
  seg7_step_counter_if.slave bus
);

  localparam int             PW       = $clog2(STEP_DIV + 1);
  localparam logic [PW-1:0]  PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [3:0]     DP_INIT  = 4'(DP_HOLD);

  state_t        state_q, state_d;
  logic          clk_div_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    value_q;
  logic          dp_q;
  logic [3:0]    dp_cnt_q;
  logic [6:0]    seg_w;

  logic          tick;
  logic          stay_run;
  logic          step;
  logic          wrap;
  logic [3:0]    value_next;
  logic [3:0]    load_sat;

  // The divider output is treated as data: a tick is its rising edge seen on clk.
  assign tick = bus.clk_div & ~clk_div_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.load)     state_d = LOAD;
        else if (bus.run) state_d = RUN;
      end
      RUN: begin
        if (bus.load)      state_d = LOAD;
        else if (!bus.run) state_d = IDLE;
      end
      LOAD: begin
        if (!bus.load) state_d = bus.run ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Steps only fire while the FSM stays in RUN, so a load or run drop suppresses them.
  always_comb begin
    stay_run   = (state_q == RUN) && (state_d == RUN);
    step       = stay_run && tick && (presc_q == PRE_LAST);
    wrap       = 1'b0;
    value_next = value_q;
    if (bus.dir) begin
      wrap       = (value_q == 4'd0);
      value_next = wrap ? VALUE_MAX : value_q - 4'd1;
    end else begin
      wrap       = (value_q == VALUE_MAX);
      value_next = wrap ? 4'd0 : value_q + 4'd1;
    end
`ifdef SEG7_DECIMAL_EN
    load_sat = (bus.load_val > VALUE_MAX) ? VALUE_MAX : bus.load_val;
`else
    load_sat = bus.load_val;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_div_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      clk_div_q <= bus.clk_div;
      state_q   <= state_d;
    end
  end

  // Prescaler holds its count through IDLE so a paused run resumes mid-interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 presc_q <= '0;
    else if (state_d == LOAD)  presc_q <= '0;
    else if (stay_run && tick) presc_q <= (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q  <= 4'd0;
      dp_q     <= 1'b0;
      dp_cnt_q <= 4'd0;
    end else if (state_d == LOAD) begin
      value_q  <= load_sat;
      dp_q     <= 1'b0;
      dp_cnt_q <= 4'd0;
    end else if (step) begin
      value_q <= value_next;
      if (wrap && step) begin
        dp_q     <= 1'b1;
        dp_cnt_q <= DP_INIT;
      end else if (dp_q) begin
        dp_cnt_q <= dp_cnt_q - 4'd1;
        if (dp_cnt_q == 4'd1) dp_q <= 1'b0;
      end
    end
  end

  seg7_encode u_encode (
    .clk   (clk),
    .reset (reset),
    .value (value_q),
    .seg   (seg_w)
  );

  assign bus.seg   = seg_w;
  assign bus.dp    = dp_q;
  assign bus.value = value_q;

endmodule
